pipeline_host_ctrl: RTL and testbench

//  Host-side sequencer for the 5-stage pipeline datapath: loads I-MEM and D-MEM (port B), runs the CPU
//  for N cycles, drains in-flight instructions with NOP injection, and reads D-MEM back.
//  One command at a time, one response per command. Owns D-MEM port B and the I-MEM write port.

---
 rtl/pipeline_host_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_host_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_host_ctrl
//  Description : Host-side sequencer for the 5-stage pipeline: loads I-MEM and
//                D-MEM port B, runs the CPU for N cycles, drains in-flight
//                instructions with NOP injection and reads D-MEM back.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_host_ctrl #(
    parameter int IMEM_AW    = 9,
    parameter int DMEM_AW    = 8,
    parameter int DMEM_DW    = 64,
    parameter int CNT_W      = 16,
    parameter int PIPE_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [IMEM_AW-1:0] cmd_addr,
    input  logic [DMEM_DW-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_op,
    output logic [DMEM_DW-1:0] rsp_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               dmem_web,
    output logic [DMEM_AW-1:0] dmem_addrb,
    output logic [DMEM_DW-1:0] dmem_dinb,
    input  logic [DMEM_DW-1:0] dmem_doutb,
    output logic               cpu_rst,
    output logic               cpu_run,
    output logic               cpu_nop
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_wr    = 3'd1;
    localparam logic [2:0] c_st_crst  = 3'd2;
    localparam logic [2:0] c_st_run   = 3'd3;
    localparam logic [2:0] c_st_drain = 3'd4;
    localparam logic [2:0] c_st_rdw   = 3'd5;
    localparam logic [2:0] c_st_rsp   = 3'd6;

    localparam logic [1:0] c_op_wr_imem = 2'd0;
    localparam logic [1:0] c_op_wr_dmem = 2'd1;
    localparam logic [1:0] c_op_run     = 2'd2;
    localparam logic [1:0] c_op_rd_dmem = 2'd3;

    localparam logic [CNT_W-1:0] c_drain_len = CNT_W'(PIPE_DEPTH);
    localparam logic [CNT_W-1:0] c_rd_wait   = CNT_W'(RD_LAT);

    logic [2:0]         r_state;
    logic [1:0]         r_op;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic [DMEM_AW-1:0] r_dmem_addr;
    logic [DMEM_DW-1:0] r_dmem_din;
    logic [CNT_W-1:0]   r_run_n;
    logic [CNT_W-1:0]   r_cnt;
    logic [DMEM_DW-1:0] r_rsp_data;

    logic               w_accept;
    logic [CNT_W-1:0]   w_cmd_n;
    logic [DMEM_DW-1:0] w_run_n_ext;

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_cmd_n     = cmd_data[CNT_W-1:0];
    assign w_run_n_ext = {{(DMEM_DW-CNT_W){1'b0}}, r_run_n};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_op         <= 2'd0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_dmem_addr  <= '0;
            r_dmem_din   <= '0;
            r_run_n      <= '0;
            r_cnt        <= '0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_op <= cmd_op;
                        case (cmd_op)
                            c_op_wr_imem: begin
                                r_imem_addr  <= cmd_addr;
                                r_imem_wdata <= cmd_data[31:0];
                                r_state      <= c_st_wr;
                            end
                            c_op_wr_dmem: begin
                                r_dmem_addr <= cmd_addr[DMEM_AW-1:0];
                                r_dmem_din  <= cmd_data;
                                r_state     <= c_st_wr;
                            end
                            c_op_run: begin
                                r_run_n <= w_cmd_n;
                                r_cnt   <= w_cmd_n;
                                // A zero-length run never touches the pipeline at all
                                if (w_cmd_n == '0) begin
                                    r_rsp_data <= '0;
                                    r_state    <= c_st_rsp;
                                end else if (cmd_addr[0]) begin
                                    r_state <= c_st_crst;
                                end else begin
                                    r_state <= c_st_run;
                                end
                            end
                            c_op_rd_dmem: begin
                                r_dmem_addr <= cmd_addr[DMEM_AW-1:0];
                                r_cnt       <= c_rd_wait;
                                r_state     <= c_st_rdw;
                            end
                            default: r_state <= c_st_idle;
                        endcase
                    end
                end
                c_st_wr: begin
                    r_rsp_data <= '0;
                    r_state    <= c_st_rsp;
                end
                c_st_crst: begin
                    r_state <= c_st_run;
                end
                c_st_run: begin
                    if (r_cnt == CNT_W'(1)) begin
                        if (PIPE_DEPTH == 0) begin
                            r_rsp_data <= w_run_n_ext;
                            r_state    <= c_st_rsp;
                        end else begin
                            r_cnt   <= c_drain_len;
                            r_state <= c_st_drain;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                c_st_drain: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_rsp_data <= w_run_n_ext;
                        r_state    <= c_st_rsp;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                c_st_rdw: begin
                    // Address went out on entry; data is valid RD_LAT cycles later
                    if (r_cnt == '0) begin
                        r_rsp_data <= dmem_doutb;
                        r_state    <= c_st_rsp;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                c_st_rsp: begin
                    if (rsp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign cmd_ready  = (r_state == c_st_idle) && !rst;
    assign rsp_valid  = (r_state == c_st_rsp);
    assign rsp_op     = r_op;
    assign rsp_data   = r_rsp_data;

    assign imem_we    = (r_state == c_st_wr) && (r_op == c_op_wr_imem);
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign dmem_web   = (r_state == c_st_wr) && (r_op == c_op_wr_dmem);
    assign dmem_addrb = r_dmem_addr;
    assign dmem_dinb  = r_dmem_din;

    assign cpu_rst    = (r_state == c_st_crst);
    assign cpu_run    = (r_state == c_st_run) || (r_state == c_st_drain);
    assign cpu_nop    = (r_state == c_st_drain);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_host_ctrl
//  Description : Self-checking bench for pipeline_host_ctrl with a D-MEM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_host_ctrl;

    localparam int IMEM_AW    = 9;
    localparam int DMEM_AW    = 8;
    localparam int DMEM_DW    = 64;
    localparam int CNT_W      = 16;
    localparam int PIPE_DEPTH = 4;
    localparam int RD_LAT     = 1;

    typedef struct packed {
        logic [1:0]  op;
        logic [8:0]  addr;
        logic [63:0] data;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [63:0] data;
    } rsp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [IMEM_AW-1:0] cmd_addr;
    logic [DMEM_DW-1:0] cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_op;
    logic [DMEM_DW-1:0] rsp_data;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               dmem_web;
    logic [DMEM_AW-1:0] dmem_addrb;
    logic [DMEM_DW-1:0] dmem_dinb;
    logic [DMEM_DW-1:0] dmem_doutb = '0;
    logic               cpu_rst;
    logic               cpu_run;
    logic               cpu_nop;

    pipeline_host_ctrl #(
        .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .DMEM_DW(DMEM_DW),
        .CNT_W(CNT_W), .PIPE_DEPTH(PIPE_DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_web(dmem_web), .dmem_addrb(dmem_addrb), .dmem_dinb(dmem_dinb),
        .dmem_doutb(dmem_doutb),
        .cpu_rst(cpu_rst), .cpu_run(cpu_run), .cpu_nop(cpu_nop)
    );

    always #5 clk = ~clk;

    // Synchronous D-MEM port B, one-cycle read latency
    logic [63:0] mem [256];
    always @(posedge clk) begin
        if (dmem_web) mem[dmem_addrb] <= dmem_dinb;
        dmem_doutb <= mem[dmem_addrb];
    end

    int c_we = 0, c_web = 0, c_rst = 0, c_run = 0, c_nop = 0, c_rv = 0, c_viol = 0;
    always @(negedge clk) begin
        if (imem_we)   c_we  <= c_we + 1;
        if (dmem_web)  c_web <= c_web + 1;
        if (cpu_rst)   c_rst <= c_rst + 1;
        if (cpu_run)   c_run <= c_run + 1;
        if (cpu_nop)   c_nop <= c_nop + 1;
        if (rsp_valid) c_rv  <= c_rv + 1;
        if ((cpu_nop && !cpu_run) || (cpu_rst && cpu_run)) c_viol <= c_viol + 1;
    end

    int   n_pass  = 0;
    int   n_total = 0;
    rsp_t exp_q[$];
    vec_t vecs[13];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic int model_lat(logic [1:0] op, logic [8:0] addr, logic [63:0] data);
        int n;
        n = int'(data[CNT_W-1:0]);
        if (op < 2'd2)  return 2;
        if (op == 2'd3) return 2 + RD_LAT;
        if (n == 0)     return 1;
        return n + PIPE_DEPTH + 1 + int'(addr[0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [8:0] addr, input logic [63:0] data,
                        input bit push, input logic [63:0] exp);
        int k;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            step();
            k++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back('{op: op, data: exp});
        step();
        cmd_valid = 1'b0;
    endtask

    // Called in the cycle after accept; leaves time at the first rsp_valid cycle
    task automatic wait_rsp(output int lat);
        int   k;
        rsp_t e;
        k = 0;
        while (!rsp_valid && k < 400) begin
            step();
            k++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            lat = -1;
            return;
        end
        lat = k + 1;
        if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_op", 64'(rsp_op), 64'(e.op));
            chk("rsp_data", rsp_data, e.data);
        end
    endtask

    initial begin
        int lat, s_we, s_web, s_rst, s_run, s_nop, s_rv, n;

        vecs[0]  = '{2'd1, 9'h010, 64'h1234, 64'h1234 & 64'h0};
        vecs[1]  = '{2'd3, 9'h010, 64'h0, 64'h1234};
        vecs[2]  = '{2'd1, 9'h0FF, 64'hDEADBEEF_CAFEF00D, 64'h0};
        vecs[3]  = '{2'd3, 9'h0FF, 64'h0, 64'hDEADBEEF_CAFEF00D};
        vecs[4]  = '{2'd3, 9'h010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234};
        vecs[5]  = '{2'd2, 9'h001, 64'd10, 64'd10};
        vecs[6]  = '{2'd2, 9'h000, 64'd0, 64'd0};
        vecs[7]  = '{2'd2, 9'h000, 64'd3, 64'd3};
        vecs[8]  = '{2'd2, 9'h001, 64'd1, 64'd1};
        vecs[9]  = '{2'd1, 9'h120, 64'h55, 64'h0};
        vecs[10] = '{2'd3, 9'h020, 64'h0, 64'h55};
        vecs[11] = '{2'd0, 9'h1FF, 64'hFFFF_FFFF_1234_5678, 64'h0};
        vecs[12] = '{2'd2, 9'h000, 64'hABCD_0000_0000_0005, 64'd5};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_cpu_run", 64'(cpu_run), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_imem_we", 64'(imem_we), 64'd0);
        chk("idle_rsp_data", rsp_data, 64'd0);

        // WR_IMEM strobe, address and data in the write cycle
        send(2'd0, 9'd5, 64'hA5A5_0001, 1'b1, 64'h0);
        chk("wr_imem_we", 64'(imem_we), 64'd1);
        chk("wr_imem_addr", 64'(imem_addr), 64'd5);
        chk("wr_imem_wdata", 64'(imem_wdata), 64'hA5A5_0001);
        wait_rsp(lat);
        chk("wr_imem_lat", 64'(lat), 64'd2);
        step();
        chk("wr_imem_we_off", 64'(imem_we), 64'd0);
        chk("wr_imem_addr_hold", 64'(imem_addr), 64'd5);

        for (int i = 0; i < 13; i++) begin
            s_we = c_we; s_web = c_web; s_rst = c_rst; s_run = c_run; s_nop = c_nop;
            n = int'(vecs[i].data[CNT_W-1:0]);
            send(vecs[i].op, vecs[i].addr, vecs[i].data, 1'b1, vecs[i].exp_data);
            wait_rsp(lat);
            step();
            chk($sformatf("v%0d_lat", i), 64'(lat),
                64'(model_lat(vecs[i].op, vecs[i].addr, vecs[i].data)));
            chk($sformatf("v%0d_imem_we", i), 64'(c_we - s_we), 64'(vecs[i].op == 2'd0));
            chk($sformatf("v%0d_dmem_web", i), 64'(c_web - s_web), 64'(vecs[i].op == 2'd1));
            chk($sformatf("v%0d_cpu_rst", i), 64'(c_rst - s_rst),
                64'(vecs[i].op == 2'd2 && n != 0 && vecs[i].addr[0]));
            chk($sformatf("v%0d_cpu_run", i), 64'(c_run - s_run),
                64'((vecs[i].op == 2'd2 && n != 0) ? n + PIPE_DEPTH : 0));
            chk($sformatf("v%0d_cpu_nop", i), 64'(c_nop - s_nop),
                64'((vecs[i].op == 2'd2 && n != 0) ? PIPE_DEPTH : 0));
        end

        // Response backpressure with a competing command waiting
        rsp_ready = 1'b0;
        s_we = c_we;
        send(2'd3, 9'h010, 64'h0, 1'b1, 64'h1234);
        wait_rsp(lat);
        chk("bp_lat", 64'(lat), 64'(2 + RD_LAT));
        cmd_op = 2'd0; cmd_addr = 9'd7; cmd_data = 64'h77; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d_valid", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp_hold%0d_data", i), rsp_data, 64'h1234);
            chk($sformatf("bp_hold%0d_ready", i), 64'(cmd_ready), 64'd0);
            step();
        end
        chk("bp_no_take", 64'(c_we - s_we), 64'd0);
        rsp_ready = 1'b1;
        chk("bp_hs_cmd_ready", 64'(cmd_ready), 64'd0);
        step();
        chk("bp_after_cmd_ready", 64'(cmd_ready), 64'd1);
        exp_q.push_back('{op: 2'd0, data: 64'h0});
        step();
        cmd_valid = 1'b0;
        chk("bp_next_we", 64'(imem_we), 64'd1);
        chk("bp_next_addr", 64'(imem_addr), 64'd7);
        wait_rsp(lat);
        step();

        // Reset in the third RUN cycle of N=20 discards the run
        s_rv = c_rv; s_run = c_run;
        send(2'd2, 9'h000, 64'd20, 1'b0, 64'h0);
        step();
        step();
        chk("rr_running", 64'(cpu_run), 64'd1);
        rst = 1'b1;
        #1;
        chk("rr_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        step();
        rst = 1'b0;
        chk("rr_cpu_run_off", 64'(cpu_run), 64'd0);
        chk("rr_cpu_nop_off", 64'(cpu_nop), 64'd0);
        for (int i = 0; i < 30; i++) step();
        chk("rr_run_cycles", 64'(c_run - s_run), 64'd3);
        chk("rr_no_rsp", 64'(c_rv - s_rv), 64'd0);
        chk("rr_cmd_ready", 64'(cmd_ready), 64'd1);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("cpu_ctrl_invariants", 64'(c_viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
